// File: rtl/gravity_sensor_pkg.sv
// gravity_sensor_pkg: shared encodings for the tilt-sensor receiver.
// Holds car_move codes plus the steering and frame state typedefs.
package gravity_sensor_pkg;

  localparam logic [1:0] MOVE_CENTER = 2'b00;
  localparam logic [1:0] MOVE_RIGHT  = 2'b01;
  localparam logic [1:0] MOVE_LEFT   = 2'b10;

  typedef enum logic [1:0] {
    ST_CENTER = MOVE_CENTER,
    ST_RIGHT  = MOVE_RIGHT,
    ST_LEFT   = MOVE_LEFT
  } steer_state_e;

  typedef enum logic {
    FR_IDLE,
    FR_ACTIVE
  } frame_state_e;

endpackage

// File: rtl/sensor_sync.sv
// sensor_sync: 2-FF synchronizer with a configurable reset value.
// Ports: clk_i, rst_i (sync, active high), d_i async in, q_o synced out.
module sensor_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/gravity_sensor_rx.sv
// gravity_sensor_rx: serial tilt-sensor receiver, frame checker, steering.
// Ports: clk1, rst, clkcs/sclk/data pins; sample, pulses, car_move, speed.
module gravity_sensor_rx
  import gravity_sensor_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int DATA_W     = 12,
  parameter int FRAME_BITS = 24,
  parameter int TH_RIGHT   = 320,
  parameter int TH_LEFT    = -257,
  parameter int HYST       = 16
) (
  input  logic                     clk1,
  input  logic                     rst,
  input  logic                     clkcs,
  input  logic                     sclk,
  input  logic                     data,
  output logic [N_CH*DATA_W-1:0]   sample,
  output logic                     sample_valid,
  output logic                     frame_err,
  output logic [1:0]               car_move,
  output logic                     speed
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam int CH_W  = $clog2(N_CH);

  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SH   = CNT_W'(FRAME_BITS - DATA_W);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);

  // One extra bit so threshold +/- HYST never wraps.
  localparam logic signed [DATA_W:0] TR  = (DATA_W+1)'(TH_RIGHT);
  localparam logic signed [DATA_W:0] TL  = (DATA_W+1)'(TH_LEFT);
  localparam logic signed [DATA_W:0] TRH = (DATA_W+1)'(TH_RIGHT - HYST);
  localparam logic signed [DATA_W:0] TLH = (DATA_W+1)'(TH_LEFT + HYST);

  logic cs_s, sck_s, dat_s;

  sensor_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .clk_i (clk1),
    .rst_i (rst),
    .d_i   (clkcs),
    .q_o   (cs_s)
  );

  sensor_sync #(.RST_VAL(1'b1)) u_sync_sck (
    .clk_i (clk1),
    .rst_i (rst),
    .d_i   (sclk),
    .q_o   (sck_s)
  );

  sensor_sync #(.RST_VAL(1'b0)) u_sync_dat (
    .clk_i (clk1),
    .rst_i (rst),
    .d_i   (data),
    .q_o   (dat_s)
  );

  logic cs_q, sck_q;
  logic [1:0] settle_q;
  logic armed_q;
  logic cs_fall, cs_rise, sck_rise;

  assign cs_fall  = cs_q & ~cs_s;
  assign cs_rise  = ~cs_q & cs_s;
  assign sck_rise = ~sck_q & sck_s;

  // The synchronizers emerge from reset reading 1; a low pin would look
  // like a falling edge. Only arm once a real high clkcs has been seen.
  always_ff @(posedge clk1) begin
    if (rst) begin
      cs_q     <= 1'b1;
      sck_q    <= 1'b1;
      settle_q <= 2'd0;
      armed_q  <= 1'b0;
    end else begin
      cs_q  <= cs_s;
      sck_q <= sck_s;
      if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
      if (settle_q == 2'd2 && cs_s) armed_q <= 1'b1;
    end
  end

  frame_state_e fr_q, fr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, cnt_e;
  logic [DATA_W-1:0] shr_q, shr_d, shr_sh, shr_e;
  logic [DATA_W-1:0] ch_q [N_CH];
  logic [DATA_W-1:0] ch_d [N_CH];
  logic [CH_W-1:0] idx_q, idx_d;
  logic [N_CH*DATA_W-1:0] sample_q, sample_d;
  logic sv_q, sv_d, fe_q, fe_d;

  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
  assign shr_sh  = {shr_q[DATA_W-2:0], dat_s};

  always_comb begin
    fr_d     = fr_q;
    cnt_d    = cnt_q;
    shr_d    = shr_q;
    ch_d     = ch_q;
    idx_d    = idx_q;
    sample_d = sample_q;
    sv_d     = 1'b0;
    fe_d     = 1'b0;
    cnt_e    = cnt_q;
    shr_e    = shr_q;
    unique case (fr_q)
      FR_IDLE: begin
        if (cs_fall && armed_q) begin
          fr_d  = FR_ACTIVE;
          cnt_d = '0;
        end
      end
      FR_ACTIVE: begin
        // A coincident sclk edge is folded in before the frame is judged.
        if (sck_rise) begin
          cnt_e = cnt_inc;
          if (cnt_inc > CNT_SH) shr_e = shr_sh;
        end
        cnt_d = cnt_e;
        shr_d = shr_e;
        if (cs_rise) begin
          fr_d = FR_IDLE;
          if (cnt_e == CNT_FULL) begin
            ch_d[idx_q] = shr_e;
            if (idx_q == CH_LAST) begin
              idx_d = '0;
              sv_d  = 1'b1;
              for (int k = 0; k < N_CH; k++) begin
                sample_d[k*DATA_W +: DATA_W] = ch_d[k];
              end
            end else begin
              idx_d = idx_q + CH_W'(1);
            end
          end else begin
            fe_d  = 1'b1;
            idx_d = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      fr_q     <= FR_IDLE;
      cnt_q    <= '0;
      shr_q    <= '0;
      ch_q     <= '{default: '0};
      idx_q    <= '0;
      sample_q <= '0;
      sv_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      fr_q     <= fr_d;
      cnt_q    <= cnt_d;
      shr_q    <= shr_d;
      ch_q     <= ch_d;
      idx_q    <= idx_d;
      sample_q <= sample_d;
      sv_q     <= sv_d;
      fe_q     <= fe_d;
    end
  end

  steer_state_e st_q, st_d;
  logic speed_q, speed_d;
  logic signed [DATA_W:0] x;

  assign x = signed'({sample_q[DATA_W-1], sample_q[DATA_W-1:0]});

  always_comb begin
    st_d    = st_q;
    speed_d = speed_q;
    if (sv_q) begin
      speed_d = sample_q[2*DATA_W-1];
      unique case (st_q)
        ST_CENTER: begin
          if (x >= TR)      st_d = ST_RIGHT;
          else if (x <= TL) st_d = ST_LEFT;
        end
        ST_RIGHT: begin
          if (x <= TL)      st_d = ST_LEFT;
          else if (x < TRH) st_d = ST_CENTER;
        end
        ST_LEFT: begin
          if (x >= TR)      st_d = ST_RIGHT;
          else if (x > TLH) st_d = ST_CENTER;
        end
        default: st_d = ST_CENTER;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      st_q    <= ST_CENTER;
      speed_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      speed_q <= speed_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sv_q;
  assign frame_err    = fe_q;
  assign car_move     = st_q;
  assign speed        = speed_q;

endmodule

// File: tb/tb_gravity_sensor_rx.sv
// tb_gravity_sensor_rx: randomized frames against a frame-level model.
// Drives the sensor pins and checks every output each cycle.
module tb_gravity_sensor_rx;

  logic clk1 = 1'b0;
  logic rst = 1'b1;
  logic clkcs = 1'b1;
  logic sclk = 1'b1;
  logic data = 1'b0;
  logic [23:0] sample;
  logic sample_valid, frame_err;
  logic [1:0] car_move;
  logic speed;

  always #5 clk1 = ~clk1;

  gravity_sensor_rx dut (
    .clk1         (clk1),
    .rst          (rst),
    .clkcs        (clkcs),
    .sclk         (sclk),
    .data         (data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .frame_err    (frame_err),
    .car_move     (car_move),
    .speed        (speed)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_err;
    logic [23:0] smp;
  } ev_t;

  ev_t expq[$];
  logic [11:0] mch [2];
  int midx = 0;

  logic [23:0] msample = '0;
  logic [1:0]  mmove = 2'b00;
  logic        mspeed = 1'b0;
  bit          pend = 0;
  logic [23:0] psmp = '0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] steer(logic [1:0] m, logic [11:0] v);
    int xv;
    xv = $signed(v);
    case (m)
      2'b01:   return (xv <= -257) ? 2'b10 : (xv < 304) ? 2'b00 : 2'b01;
      2'b10:   return (xv >= 320) ? 2'b01 : (xv > -241) ? 2'b00 : 2'b10;
      default: return (xv >= 320) ? 2'b01 : (xv <= -257) ? 2'b10 : 2'b00;
    endcase
  endfunction

  always @(negedge clk1) begin
    if (rst) begin
      msample = '0;
      mmove   = 2'b00;
      mspeed  = 1'b0;
      pend    = 0;
    end else begin
      if (pend) begin
        mmove  = steer(mmove, psmp[11:0]);
        mspeed = psmp[23];
        pend   = 0;
      end
      chk("pulse_excl", {31'd0, sample_valid & frame_err}, 32'd0);
      if (sample_valid) begin
        checks++;
        if (expq.size() == 0 || expq[0].is_err) begin
          errors++;
          $display("FAIL valid got sample_valid=1 want no pulse");
        end else begin
          msample = expq[0].smp;
          psmp    = expq[0].smp;
          pend    = 1;
        end
        if (expq.size() > 0) void'(expq.pop_front());
      end
      if (frame_err) begin
        checks++;
        if (expq.size() == 0 || !expq[0].is_err) begin
          errors++;
          $display("FAIL ferr got frame_err=1 want no pulse");
        end
        if (expq.size() > 0) void'(expq.pop_front());
      end
      chk("sample", {8'd0, sample}, {8'd0, msample});
      chk("car_move", {30'd0, car_move}, {30'd0, mmove});
      chk("speed", {31'd0, speed}, {31'd0, mspeed});
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk1);
    #2;
  endtask

  task automatic edges(int ne, logic [11:0] v);
    for (int i = 0; i < ne; i++) begin
      int j;
      j = i - (ne - 12);
      sclk = 1'b0;
      data = (j >= 0) ? v[11-j] : 1'($urandom_range(0, 1));
      cyc(3);
      sclk = 1'b1;
      cyc(3);
    end
  endtask

  task automatic frame(int ne, logic [11:0] v);
    ev_t e;
    clkcs = 1'b0;
    cyc(3);
    edges(ne, v);
    cyc(2);
    if (ne == 24) begin
      mch[midx] = v;
      if (midx == 1) begin
        e.is_err = 0;
        e.smp = {mch[1], mch[0]};
        expq.push_back(e);
      end
      midx = (midx + 1) % 2;
    end else begin
      e.is_err = 1;
      e.smp = '0;
      expq.push_back(e);
      midx = 0;
    end
    clkcs = 1'b1;
    cyc(8);
  endtask

  task automatic round(logic [11:0] xv, logic [11:0] yv);
    frame(24, xv);
    frame(24, yv);
    cyc(2);
  endtask

  function automatic logic [11:0] rand_x();
    int sel;
    sel = $urandom_range(0, 3);
    case (sel)
      0:       return 12'(320 + $urandom_range(0, 40) - 20);
      1:       return 12'(-257 + $urandom_range(0, 40) - 20);
      2:       return 12'(-241 + $urandom_range(0, 6) - 3);
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  initial begin
    mch[0] = '0;
    mch[1] = '0;
    rst = 1'b1;
    cyc(4);
    rst = 1'b0;
    cyc(3);
    chk("rst_sample", {8'd0, sample}, 32'd0);
    chk("rst_move", {30'd0, car_move}, 32'd0);
    chk("rst_speed", {31'd0, speed}, 32'd0);
    chk("rst_valid", {31'd0, sample_valid}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);

    round(12'h140, 12'h800);
    chk("happy_sample", {8'd0, sample}, 32'h0080_0140);
    chk("happy_move", {30'd0, car_move}, 32'd1);
    chk("happy_speed", {31'd0, speed}, 32'd1);

    round(12'hEFF, 12'h010);
    chk("left_entry", {30'd0, car_move}, 32'd2);
    chk("left_speed", {31'd0, speed}, 32'd0);
    round(12'hF06, 12'h010);
    chk("left_hold", {30'd0, car_move}, 32'd2);
    round(12'hF10, 12'h010);
    chk("left_release", {30'd0, car_move}, 32'd0);

    round(12'h140, 12'h010);
    chk("right_entry", {30'd0, car_move}, 32'd1);
    round(12'h136, 12'h010);
    chk("right_hold", {30'd0, car_move}, 32'd1);
    round(12'h12F, 12'h010);
    chk("right_release", {30'd0, car_move}, 32'd0);
    round(12'h140, 12'h010);
    round(12'hED4, 12'h010);
    chk("right_to_left", {30'd0, car_move}, 32'd2);

    frame(23, 12'h3A5);
    round(12'h055, 12'h923);
    chk("after_short", {8'd0, sample}, 32'h0092_3055);
    chk("after_short_spd", {31'd0, speed}, 32'd1);

    frame(24, 12'h777);
    frame(26, 12'h111);
    round(12'h0AB, 12'h0CD);
    chk("after_long", {8'd0, sample}, 32'h000C_D0AB);

    clkcs = 1'b0;
    cyc(3);
    edges(10, 12'hFFF);
    rst = 1'b1;
    expq.delete();
    mch[0] = '0;
    mch[1] = '0;
    midx = 0;
    cyc(3);
    rst = 1'b0;
    cyc(4);
    chk("midrst_sample", {8'd0, sample}, 32'd0);
    chk("midrst_move", {30'd0, car_move}, 32'd0);
    clkcs = 1'b1;
    cyc(6);
    round(12'hE00, 12'h7FF);
    chk("midrst_round", {8'd0, sample}, 32'h007F_FE00);
    chk("midrst_movechk", {30'd0, car_move}, 32'd2);

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 5) == 0) begin
        int ne;
        ne = $urandom_range(18, 28);
        if (ne == 24) ne = 25;
        frame(ne, 12'($urandom_range(0, 4095)));
      end else begin
        frame(24, rand_x());
        frame(24, 12'($urandom_range(0, 4095)));
      end
    end

    cyc(10);
    chk("queue_empty", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
